pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-to-hazard-unit bundle: register indices and hazard inputs in, stall/flush/forward controls out.
// master = pipeline side driving operands and hazard inputs; slave = the hazard unit.
interface pipe_hazard_ctrl_if;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic [3:0]  ex_rd;
  logic        ex_load;
  logic [3:0]  mem_rd;
  logic        br_taken;
  logic        mem_busy;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_hold;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_rd, ex_load, mem_rd, br_taken, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rd, ex_load, mem_rd, br_taken, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flow control: load-use stall, branch flush, memory freeze and operand forwarding.
// Zero-cycle combinational controls; mem_busy freezes all state and overrides every other hazard.
module pipe_hazard_ctrl #(
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [3:0] REG_NONE   = 4'hF;
  localparam logic [3:0] FLUSH_INIT = (BR_PENALTY > 1) ? 4'(BR_PENALTY - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] stall_cnt_q;

  logic       pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use;

  // EX forwarding is impossible for a load: its data only exists once it reaches MEM.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic [3:0] ex_rd,
                                         input logic ex_load, input logic [3:0] mem_rd);
    if (src != REG_NONE && src == ex_rd && !ex_load) return 2'b01;
    if (src != REG_NONE && src == mem_rd)            return 2'b10;
    return 2'b00;
  endfunction

  assign load_use = hz.ex_load && (hz.ex_rd != REG_NONE) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    fwd_a       = fwd_sel(hz.id_rs, hz.ex_rd, hz.ex_load, hz.mem_rd);
    fwd_b       = fwd_sel(hz.id_rt, hz.ex_rd, hz.ex_load, hz.mem_rd);
    state_d     = state_q;
    fcnt_d      = fcnt_q;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      state_d     = RUN;
      fcnt_d      = 4'd0;
    end else if (hz.mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_hold = 1'b1;
    end else if (hz.br_taken || state_q == FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      // A taken branch restarts the penalty window, even mid-flush.
      if (hz.br_taken) begin
        if (BR_PENALTY > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end else begin
          state_d = RUN;
        end
      end else if (fcnt_q == 4'd0) begin
        state_d = RUN;
      end else begin
        fcnt_d = fcnt_q - 4'd1;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!pc_en && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.pipe_hold   = pipe_hold;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (BR_PENALTY 1, 2, 5) share stimulus and are
// checked every cycle against a remaining-penalty model, plus literal directed expectations.
module tb_pipe_hazard_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_load, br_taken, mem_busy;

  logic [N-1:0] pc_en_w, ifid_en_w, ifid_flush_w, bub_w, hold_w;
  logic [1:0]   fa_w [N];
  logic [1:0]   fb_w [N];
  logic [15:0]  sc_w [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? 1 : (g == 1) ? 2 : 5;
    pipe_hazard_ctrl_if ifc ();
    assign ifc.id_rs    = id_rs;
    assign ifc.id_rt    = id_rt;
    assign ifc.ex_rd    = ex_rd;
    assign ifc.ex_load  = ex_load;
    assign ifc.mem_rd   = mem_rd;
    assign ifc.br_taken = br_taken;
    assign ifc.mem_busy = mem_busy;
    assign pc_en_w[g]      = ifc.pc_en;
    assign ifid_en_w[g]    = ifc.ifid_en;
    assign ifid_flush_w[g] = ifc.ifid_flush;
    assign bub_w[g]        = ifc.idex_bubble;
    assign hold_w[g]       = ifc.pipe_hold;
    assign fa_w[g]         = ifc.fwd_a;
    assign fb_w[g]         = ifc.fwd_b;
    assign sc_w[g]         = ifc.stall_cnt;
    pipe_hazard_ctrl #(.BR_PENALTY(P)) u_dut (.clk(clk), .rst(rst), .hz(ifc));
  end

  int checks = 0;
  int errors = 0;
  int rem [N];
  int cnt [N];

  function automatic int pen_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 5;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s[P=%0d] @%0t: got 0x%0h expected 0x%0h", name, pen_of(idx), $time, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl_of(input int i);
    return {pc_en_w[i], ifid_en_w[i], ifid_flush_w[i], bub_w[i], hold_w[i]};
  endfunction

  function automatic logic [1:0] fw(input logic [3:0] s);
    if (s != 4'hF && s == ex_rd && !ex_load) return 2'd1;
    if (s != 4'hF && s == mem_rd) return 2'd2;
    return 2'd0;
  endfunction

  // Model: rem = bubble cycles still owed to a taken branch after the current one.
  always @(negedge clk) begin : cmp
    logic [4:0] e;
    logic       lu;
    for (int i = 0; i < N; i++) begin
      lu = ex_load && ex_rd != 4'hF && (ex_rd == id_rs || ex_rd == id_rt);
      if (rst)                         e = 5'b00110;
      else if (mem_busy)               e = 5'b00001;
      else if (br_taken || rem[i] > 0) e = 5'b11110;
      else if (lu)                     e = 5'b00010;
      else                             e = 5'b11000;
      chk("ctl", i, 32'(ctl_of(i)), 32'(e));
      chk("fwd", i, {28'd0, fa_w[i], fb_w[i]}, rst ? 32'd0 : {28'd0, fw(id_rs), fw(id_rt)});
      chk("stall_cnt", i, 32'(sc_w[i]), cnt[i]);
      if (rst) begin
        rem[i] = 0;
        cnt[i] = 0;
      end else begin
        if (!e[4] && cnt[i] < 65535) cnt[i]++;
        if (!mem_busy) begin
          if (br_taken) rem[i] = pen_of(i) - 1;
          else if (rem[i] > 0) rem[i]--;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
    rst = 1'b1; ex_load = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
    id_rs = 4'hF; id_rt = 4'hF; ex_rd = 4'hF; mem_rd = 4'hF;
    @(negedge clk); chk("lit_rst_ctl", 1, 32'(ctl_of(1)), 32'b00110);
    nxt; rst = 1'b0; id_rs = 4'd3; id_rt = 4'd4;
    @(negedge clk);
    chk("lit_norm_ctl", 1, 32'(ctl_of(1)), 32'b11000);
    chk("lit_norm_fwd", 1, {28'd0, fa_w[1], fb_w[1]}, 32'd0);
    chk("lit_norm_sc", 1, 32'(sc_w[1]), 32'd0);
    nxt; ex_load = 1'b1; ex_rd = 4'd5; id_rt = 4'd5;
    @(negedge clk); chk("lit_lu_ctl", 1, 32'(ctl_of(1)), 32'b00010);
    nxt; ex_load = 1'b0; ex_rd = 4'hF; mem_rd = 4'd5;
    @(negedge clk);
    chk("lit_lu_fwdb", 1, 32'(fb_w[1]), 32'd2);
    chk("lit_lu_sc", 1, 32'(sc_w[1]), 32'd1);
    chk("lit_lu_after", 1, 32'(ctl_of(1)), 32'b11000);
    nxt; mem_rd = 4'hF; id_rt = 4'd4; br_taken = 1'b1;
    @(negedge clk);
    chk("lit_br0_p2", 1, 32'(ctl_of(1)), 32'b11110);
    chk("lit_br0_p1", 0, 32'(ctl_of(0)), 32'b11110);
    nxt; br_taken = 1'b0;
    @(negedge clk);
    chk("lit_br1_p2", 1, 32'(ctl_of(1)), 32'b11110);
    chk("lit_br1_p1", 0, 32'(ctl_of(0)), 32'b11000);
    nxt;
    @(negedge clk); chk("lit_br2_p2", 1, 32'(ctl_of(1)), 32'b11000);
    nxt; br_taken = 1'b1;
    @(negedge clk); chk("lit_brb0", 1, 32'(ctl_of(1)), 32'b11110);
    nxt; br_taken = 1'b0; mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("lit_busy", 1, 32'(ctl_of(1)), 32'b00001);
      nxt;
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("lit_brb_tail", 1, 32'(ctl_of(1)), 32'b11110);
    chk("lit_brb_p1", 0, 32'(ctl_of(0)), 32'b11000);
    nxt;
    @(negedge clk);
    chk("lit_brb_done", 1, 32'(ctl_of(1)), 32'b11000);
    chk("lit_brb_sc", 1, 32'(sc_w[1]), 32'd4);
    nxt; id_rs = 4'd7; ex_rd = 4'd7; mem_rd = 4'd7;
    @(negedge clk); chk("lit_fwd_ex", 1, 32'(fa_w[1]), 32'd1);
    nxt; id_rs = 4'hF; ex_rd = 4'hF;
    @(negedge clk); chk("lit_fwd_none", 1, 32'(fa_w[1]), 32'd0);
    nxt; id_rs = 4'd7; ex_rd = 4'd7; ex_load = 1'b1;
    @(negedge clk);
    chk("lit_fwd_ldmem", 1, 32'(fa_w[1]), 32'd2);
    chk("lit_fwd_ldctl", 1, 32'(ctl_of(1)), 32'b00010);
    nxt; ex_load = 1'b0; id_rs = 4'hF; id_rt = 4'hF; ex_rd = 4'hF; mem_rd = 4'hF;

    repeat (4000) begin
      rst      = ($urandom_range(0, 63) == 0);
      id_rs    = rnd_reg();
      id_rt    = rnd_reg();
      ex_rd    = rnd_reg();
      mem_rd   = rnd_reg();
      ex_load  = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 9) == 0);
      nxt;
    end

    rst = 1'b0; br_taken = 1'b0; ex_load = 1'b0; mem_busy = 1'b1;
    id_rs = 4'hF; id_rt = 4'hF; ex_rd = 4'hF; mem_rd = 4'hF;
    repeat (70000) nxt;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("lit_sat", i, 32'(sc_w[i]), 32'hFFFF);
    nxt; mem_busy = 1'b0; rst = 1'b1;
    @(negedge clk); chk("lit_rst2_ctl", 1, 32'(ctl_of(1)), 32'b00110);
    nxt; rst = 1'b0;
    @(negedge clk);
    chk("lit_rst2_sc", 1, 32'(sc_w[1]), 32'd0);
    chk("lit_rst2_ctl_n", 1, 32'(ctl_of(1)), 32'b11000);
    nxt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
